// File: rtl/arm_flags_pkg.sv
// Shared definitions for the {N,Z,C,V} status-flag producer: ALU command
// codes, flag bit positions, update masks and the in-flight entry format.
package arm_flags_pkg;

    typedef enum logic [3:0] {
        CMD_MOV = 4'b0001,
        CMD_ADD = 4'b0010,
        CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SBC = 4'b0101,
        CMD_AND = 4'b0110,
        CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000,
        CMD_MVN = 4'b1001
    } alu_cmd_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] MASK_ARITH = 4'b1111;
    localparam logic [3:0] MASK_LOGIC = 4'b1110;
    localparam logic [3:0] MASK_NONE  = 4'b0000;

    typedef struct packed {
        logic       valid;
        logic [3:0] flags;
        logic [3:0] mask;
    } flag_entry_t;

    localparam int ENTRY_W = $bits(flag_entry_t);

    // Merge one masked update into a status register value.
    function automatic logic [3:0] apply_update(input logic [3:0] cur,
                                                input logic [3:0] flags,
                                                input logic [3:0] mask);
        return (cur & ~mask) | (flags & mask);
    endfunction

endpackage

// File: rtl/flag_gen.sv
// Combinational flag and mask generation for one ALU command in EXE.
module flag_gen
    import arm_flags_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       exe_cmd,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             shifter_carry,
    output logic [3:0]       flags,
    output logic [3:0]       mask
);

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic signed [WIDTH-1:0] r_s;
    logic                    a_neg;
    logic                    b_neg;
    logic                    r_neg;
    logic                    add_ovf;
    logic                    sub_ovf;

    assign a_s   = op_a;
    assign b_s   = op_b;
    assign r_s   = alu_result;
    assign a_neg = a_s[WIDTH-1];
    assign b_neg = b_s[WIDTH-1];
    assign r_neg = r_s[WIDTH-1];

    // Two's-complement overflow: same-signed operands give a differently
    // signed sum; for subtraction the operand signs must differ instead.
    assign add_ovf = (a_neg == b_neg) && (r_neg != a_neg);
    assign sub_ovf = (a_neg != b_neg) && (r_neg != a_neg);

    // Select carry/overflow sources and the write mask from the command class.
    always_comb begin
        flags         = '0;
        mask          = MASK_NONE;
        flags[FLAG_N] = r_neg;
        flags[FLAG_Z] = (alu_result == '0);
        case (exe_cmd)
            CMD_ADD, CMD_ADC: begin
                flags[FLAG_C] = alu_carry;
                flags[FLAG_V] = add_ovf;
                mask          = MASK_ARITH;
            end
            CMD_SUB, CMD_SBC: begin
                flags[FLAG_C] = alu_carry;
                flags[FLAG_V] = sub_ovf;
                mask          = MASK_ARITH;
            end
            CMD_MOV, CMD_MVN, CMD_AND, CMD_ORR, CMD_EOR: begin
                flags[FLAG_C] = shifter_carry;
                mask          = MASK_LOGIC;
            end
            default: mask = MASK_NONE;
        endcase
    end

endmodule

// File: rtl/status_flag_unit.sv
// Status register producer: captures S-suffixed ALU flag updates in EXE,
// carries them through LATENCY-1 intermediate stages and commits them to the
// architectural {N,Z,C,V} register, exposing a forwarded view and a busy flag.
module status_flag_unit
    import arm_flags_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int WIDTH   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inst_valid,
    input  logic             s_bit,
    input  logic             cond_pass,
    input  logic [3:0]       exe_cmd,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             shifter_carry,
    input  logic             stall,
    input  logic             flush,
    output logic [3:0]       sr,
    output logic [3:0]       sr_fwd,
    output logic             flags_busy
);

    logic        capture;
    logic [3:0]  gen_flags;
    logic [3:0]  gen_mask;
    flag_entry_t entry_p0;

    assign capture = inst_valid & s_bit & cond_pass & ~stall & ~flush;

    flag_gen #(
        .WIDTH(WIDTH)
    ) u_flag_gen (
        .exe_cmd      (exe_cmd),
        .op_a         (op_a),
        .op_b         (op_b),
        .alu_result   (alu_result),
        .alu_carry    (alu_carry),
        .shifter_carry(shifter_carry),
        .flags        (gen_flags),
        .mask         (gen_mask)
    );

    // ---- EXE: entry formed combinationally (stage 0) ----
    assign entry_p0 = '{valid: capture, flags: gen_flags, mask: gen_mask};

    if (LATENCY <= 1) begin : g_direct

        // Commit the EXE entry straight into the status register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sr <= 4'b0000;
            end else if (entry_p0.valid) begin
                sr <= apply_update(sr, entry_p0.flags, entry_p0.mask);
            end
        end

        assign sr_fwd     = sr;
        assign flags_busy = 1'b0;

    end else begin : g_piped

        localparam int NSTG = LATENCY - 1;

        // Index 0 is the newest stage (stage 1), NSTG-1 the oldest.
        logic [NSTG-1:0] vld_p;
        logic [3:0]      flags_p [NSTG];
        logic [3:0]      mask_p  [NSTG];

        // ---- Stages 1..LATENCY-1: control (valids) and commit from the last stage ----
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sr    <= 4'b0000;
                vld_p <= '0;
            end else if (flush) begin
                vld_p <= '0;
            end else if (!stall) begin
                for (int i = NSTG - 1; i > 0; i--) begin
                    vld_p[i] <= vld_p[i-1];
                end
                vld_p[0] <= entry_p0.valid;
                if (vld_p[NSTG-1]) begin
                    sr <= apply_update(sr, flags_p[NSTG-1], mask_p[NSTG-1]);
                end
            end
        end

        // Shift flag/mask payload alongside the valids; meaningless when invalid.
        always_ff @(posedge clk) begin
            if (!stall) begin
                for (int i = NSTG - 1; i > 0; i--) begin
                    flags_p[i] <= flags_p[i-1];
                    mask_p[i]  <= mask_p[i-1];
                end
                flags_p[0] <= entry_p0.flags;
                mask_p[0]  <= entry_p0.mask;
            end
        end

        // Forward view: committed SR with in-flight updates applied oldest first.
        always_comb begin
            sr_fwd = sr;
            for (int i = NSTG - 1; i >= 0; i--) begin
                if (vld_p[i]) begin
                    sr_fwd = apply_update(sr_fwd, flags_p[i], mask_p[i]);
                end
            end
        end

        assign flags_busy = |vld_p;

    end

endmodule

// File: tb/tb_status_flag_unit.sv
// Self-checking bench for status_flag_unit at LATENCY=1 and LATENCY=3.
module tb_status_flag_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_valid, s_bit, cond_pass, alu_carry, shifter_carry, stall, flush;
    logic [3:0]  exe_cmd;
    logic [31:0] op_a, op_b, alu_result;
    logic [3:0]  sr1, fwd1, sr3, fwd3;
    logic        busy1, busy3;

    always #5 clk = ~clk;

    status_flag_unit #(.LATENCY(1), .WIDTH(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .s_bit(s_bit),
        .cond_pass(cond_pass), .exe_cmd(exe_cmd), .op_a(op_a), .op_b(op_b),
        .alu_result(alu_result), .alu_carry(alu_carry), .shifter_carry(shifter_carry),
        .stall(stall), .flush(flush), .sr(sr1), .sr_fwd(fwd1), .flags_busy(busy1));

    status_flag_unit #(.LATENCY(3), .WIDTH(32)) dut3 (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .s_bit(s_bit),
        .cond_pass(cond_pass), .exe_cmd(exe_cmd), .op_a(op_a), .op_b(op_b),
        .alu_result(alu_result), .alu_carry(alu_carry), .shifter_carry(shifter_carry),
        .stall(stall), .flush(flush), .sr(sr3), .sr_fwd(fwd3), .flags_busy(busy3));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int         k;
        logic [3:0] f;
        logic [3:0] m;
        int         rem;
    } pend_t;

    pend_t      pq[$];
    logic [3:0] msr[2];

    function automatic logic [3:0] merge(input logic [3:0] cur, input logic [3:0] f, input logic [3:0] m);
        logic [3:0] v;
        v = cur;
        for (int b = 0; b < 4; b++) if (m[b]) v[b] = f[b];
        return v;
    endfunction

    // One clock edge for model k with the given latency.
    task automatic model_edge(input int k, input int lat, input bit cap,
                              input logic [3:0] f, input logic [3:0] m,
                              input bit st, input bit fl);
        pend_t nq[$];
        pend_t it;
        if (st && !fl) return;
        foreach (pq[i]) begin
            if (pq[i].k != k) nq.push_back(pq[i]);
            else if (!fl) begin
                if (pq[i].rem == 1) msr[k] = merge(msr[k], pq[i].f, pq[i].m);
                else begin
                    it = pq[i];
                    it.rem = it.rem - 1;
                    nq.push_back(it);
                end
            end
        end
        if (cap && !fl && !st) begin
            if (lat == 1) msr[k] = merge(msr[k], f, m);
            else begin
                it.k = k; it.f = f; it.m = m; it.rem = lat - 1;
                nq.push_back(it);
            end
        end
        pq = nq;
    endtask

    function automatic logic [3:0] model_fwd(input int k);
        logic [3:0] v;
        v = msr[k];
        foreach (pq[i]) if (pq[i].k == k) v = merge(v, pq[i].f, pq[i].m);
        return v;
    endfunction

    function automatic logic model_busy(input int k);
        foreach (pq[i]) if (pq[i].k == k) return 1'b1;
        return 1'b0;
    endfunction

    // ALU behaviour from arithmetic: result, carry-out and expected flags/mask.
    task automatic alu_ref(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                           input bit cin, input bit shc,
                           output logic [31:0] r, output logic carry,
                           output logic [3:0] f, output logic [3:0] m);
        longint     sa, sb, s;
        logic [32:0] w;
        bit         arith;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s = 0; w = '0; arith = 1'b0;
        r = $urandom; carry = 1'($urandom_range(0, 1));
        f = '0; m = 4'b0000;
        case (cmd)
            4'd2: begin w = {1'b0, a} + {1'b0, b};                 s = sa + sb;                 arith = 1; end
            4'd3: begin w = {1'b0, a} + {1'b0, b} + 33'(cin);      s = sa + sb + longint'(cin); arith = 1; end
            4'd4: begin w = {1'b0, a} + {1'b0, ~b} + 33'd1;        s = sa - sb;                 arith = 1; end
            4'd5: begin w = {1'b0, a} + {1'b0, ~b} + 33'(cin);     s = sa - sb - 1 + longint'(cin); arith = 1; end
            4'd1: begin r = b;     m = 4'b1110; end
            4'd9: begin r = ~b;    m = 4'b1110; end
            4'd6: begin r = a & b; m = 4'b1110; end
            4'd7: begin r = a | b; m = 4'b1110; end
            4'd8: begin r = a ^ b; m = 4'b1110; end
            default: m = 4'b0000;
        endcase
        if (arith) begin
            r = w[31:0];
            carry = w[32];
            m = 4'b1111;
            f = {r[31], (r == 0), carry, (s > 64'sd2147483647 || s < -64'sd2147483648)};
        end else begin
            f = {r[31], (r == 0), shc, 1'b0};
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_valid = 0; s_bit = 0; cond_pass = 0; exe_cmd = 4'd0;
        op_a = '0; op_b = '0; alu_result = '0; alu_carry = 0; shifter_carry = 0;
    endtask

    task automatic drive(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic c, input logic shc);
        inst_valid = 1; s_bit = 1; cond_pass = 1; exe_cmd = cmd;
        op_a = a; op_b = b; alu_result = r; alu_carry = c; shifter_carry = shc;
    endtask

    task automatic do_reset();
        idle(); stall = 0; flush = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_sr1", sr1, 4'b0000);
        chk("reset_sr3", sr3, 4'b0000);
        chk("reset_fwd3", fwd3, 4'b0000);
        chk("reset_busy3", busy3, 1'b0);
        rst_n = 1;
        pq.delete();
        msr[0] = 4'b0000;
        msr[1] = 4'b0000;
    endtask

    typedef struct {
        logic        iv, sb, cp;
        logic [3:0]  cmd;
        logic [31:0] a, b, r;
        logic        c, shc;
        logic [3:0]  exp_sr;
    } vec_t;

    vec_t tbl[14];

    initial begin
        bit          r_iv, r_sb, r_cp, r_st, r_fl, cin, shc, cap;
        logic [3:0]  cmd, ef, em;
        logic [31:0] a, b, r;
        logic        carry;
        logic [31:0] specials[4];

        specials[0] = 32'h0000_0000; specials[1] = 32'h7FFF_FFFF;
        specials[2] = 32'h8000_0000; specials[3] = 32'hFFFF_FFFF;

        //                iv    sb    cp    cmd    a             b             r             c     shc   sr
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 4'h2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 4'b1001};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 4'h4, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 4'b0110};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 4'h6, 32'h0000F000, 32'h00000F00, 32'h00000000, 1'b1, 1'b0, 4'b0100};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 4'h2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 4'b1001};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 4'h7, 32'h00000000, 32'h00000001, 32'h00000001, 1'b0, 1'b1, 4'b0011};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 4'h2, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 4'b0011};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 4'h2, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 4'b0011};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 4'h2, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 4'b0011};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 4'hF, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 4'b0011};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 4'h9, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0, 4'b1001};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 4'h5, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 4'b0011};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 4'h3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 4'b0110};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 4'h8, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0, 1'b1, 4'b1010};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 4'h1, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 4'b0110};

        do_reset();

        // Table vectors against the single-edge unit.
        for (int i = 0; i < 14; i++) begin
            inst_valid = tbl[i].iv; s_bit = tbl[i].sb; cond_pass = tbl[i].cp;
            exe_cmd = tbl[i].cmd; op_a = tbl[i].a; op_b = tbl[i].b;
            alu_result = tbl[i].r; alu_carry = tbl[i].c; shifter_carry = tbl[i].shc;
            tick();
            chk($sformatf("tbl%0d_sr1", i), sr1, tbl[i].exp_sr);
            chk($sformatf("tbl%0d_fwd1", i), fwd1, tbl[i].exp_sr);
            chk($sformatf("tbl%0d_busy1", i), busy1, 1'b0);
        end
        idle();

        // LATENCY=3: capture, two busy edges, commit on the third.
        do_reset();
        drive(4'h2, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
        chk("l3_busy_pre", busy3, 1'b0);
        tick(); idle();
        chk("l3_e1_busy", busy3, 1'b1);
        chk("l3_e1_fwd", fwd3, 4'b0110);
        chk("l3_e1_sr", sr3, 4'b0000);
        tick();
        chk("l3_e2_busy", busy3, 1'b1);
        chk("l3_e2_sr", sr3, 4'b0000);
        tick();
        chk("l3_e3_sr", sr3, 4'b0110);
        chk("l3_e3_busy", busy3, 1'b0);
        chk("l3_e3_fwd", fwd3, 4'b0110);

        // Stall held four cycles with an entry in stage 1.
        drive(4'h7, 32'h00000000, 32'h80000000, 32'h80000000, 1'b1, 1'b0);
        tick(); idle();
        stall = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("stall%0d_busy", i), busy3, 1'b1);
            chk($sformatf("stall%0d_sr", i), sr3, 4'b0110);
            chk($sformatf("stall%0d_fwd", i), fwd3, 4'b1000);
        end
        stall = 0;
        tick();
        chk("unstall1_sr", sr3, 4'b0110);
        chk("unstall1_busy", busy3, 1'b1);
        tick();
        chk("unstall2_sr", sr3, 4'b1000);
        chk("unstall2_busy", busy3, 1'b0);

        // Stall together with flush kills the in-flight entry.
        drive(4'h2, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
        tick(); idle();
        stall = 1; flush = 1;
        tick();
        stall = 0; flush = 0;
        chk("stflush_busy", busy3, 1'b0);
        chk("stflush_fwd", fwd3, 4'b1000);
        repeat (3) tick();
        chk("stflush_sr", sr3, 4'b1000);

        // Flush with the entry sitting in the last stage: no commit.
        drive(4'h2, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
        tick(); idle();
        tick();
        flush = 1;
        tick();
        flush = 0;
        chk("lastflush_sr", sr3, 4'b1000);
        chk("lastflush_busy", busy3, 1'b0);
        tick();
        chk("lastflush_sr_late", sr3, 4'b1000);

        // Asynchronous reset between edges while an entry is in flight.
        drive(4'h2, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
        tick(); idle();
        #3 rst_n = 0;
        #1;
        chk("async_sr3", sr3, 4'b0000);
        chk("async_busy3", busy3, 1'b0);
        chk("async_fwd3", fwd3, 4'b0000);
        chk("async_sr1", sr1, 4'b0000);
        @(posedge clk);
        #2 rst_n = 1;
        repeat (4) tick();
        chk("async_late_sr3", sr3, 4'b0000);
        chk("async_late_busy3", busy3, 1'b0);

        // Randomized traffic against the reference model for both latencies.
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            r_iv = ($urandom_range(0, 9) < 8);
            r_sb = ($urandom_range(0, 3) != 0);
            r_cp = ($urandom_range(0, 4) != 0);
            r_st = ($urandom_range(0, 5) == 0);
            r_fl = ($urandom_range(0, 11) == 0);
            cin  = 1'($urandom_range(0, 1));
            shc  = 1'($urandom_range(0, 1));
            cmd  = 4'($urandom_range(0, 15));
            a    = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = specials[$urandom_range(0, 3)];
                default: b = $urandom;
            endcase
            alu_ref(cmd, a, b, cin, shc, r, carry, ef, em);
            inst_valid = r_iv; s_bit = r_sb; cond_pass = r_cp; stall = r_st; flush = r_fl;
            exe_cmd = cmd; op_a = a; op_b = b; alu_result = r;
            alu_carry = carry; shifter_carry = shc;
            cap = r_iv & r_sb & r_cp & ~r_st & ~r_fl;
            @(negedge clk);
            chk($sformatf("rnd%0d_sr1", cyc), sr1, msr[0]);
            chk($sformatf("rnd%0d_fwd1", cyc), fwd1, model_fwd(0));
            chk($sformatf("rnd%0d_busy1", cyc), busy1, model_busy(0));
            chk($sformatf("rnd%0d_sr3", cyc), sr3, msr[1]);
            chk($sformatf("rnd%0d_fwd3", cyc), fwd3, model_fwd(1));
            chk($sformatf("rnd%0d_busy3", cyc), busy3, model_busy(1));
            model_edge(0, 1, cap, ef, em, r_st, r_fl);
            model_edge(1, 3, cap, ef, em, r_st, r_fl);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
